// File: rtl/tl_ul_a_source_arbiter_pkg.sv
// tl_ul_a_source_arbiter_pkg: TL-UL opcodes, field widths and A/D channel structs shared by the arbiter slice
package tl_ul_a_source_arbiter_pkg;
  localparam int SRC_W = 5;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;
  localparam logic [2:0] OP_GET = 3'd4;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ACCESS_ACK = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] param;
    logic [3:0] size;
    logic [SRC_W-1:0] source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } a_chan_t;
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] param;
    logic [3:0] size;
    logic [SRC_W-1:0] source;
    logic denied;
    logic corrupt;
    logic [DATA_W-1:0] data;
  } d_chan_t;
endpackage

// File: rtl/tl_ul_a_source_arbiter_if.sv
// tl_ul_a_source_arbiter_if: requester-side and downstream TL-UL signals of the source arbiter
// master: arbiter view (drives merged A, requester A ready, routed D, d_ready)
// slave:  environment view (drives requester A, a_ready, downstream D, requester D ready)
// Requester vectors are packed, requester i at [W*i +: W].
interface tl_ul_a_source_arbiter_if
  import tl_ul_a_source_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W = $clog2(NUM_REQ),
  parameter int UW = SRC_W - IDX_W
);
  logic [NUM_REQ-1:0] req_a_valid;
  logic [NUM_REQ-1:0] req_a_ready;
  logic [3*NUM_REQ-1:0] req_a_opcode;
  logic [3*NUM_REQ-1:0] req_a_param;
  logic [4*NUM_REQ-1:0] req_a_size;
  logic [UW*NUM_REQ-1:0] req_a_source;
  logic [ADDR_W*NUM_REQ-1:0] req_a_address;
  logic [MASK_W*NUM_REQ-1:0] req_a_mask;
  logic [DATA_W*NUM_REQ-1:0] req_a_data;
  logic a_valid;
  logic a_ready;
  a_chan_t a;
  logic d_valid;
  logic d_ready;
  d_chan_t d;
  logic [NUM_REQ-1:0] req_d_valid;
  logic [NUM_REQ-1:0] req_d_ready;
  logic [2:0] req_d_opcode;
  logic [1:0] req_d_param;
  logic [3:0] req_d_size;
  logic [UW-1:0] req_d_source;
  logic req_d_denied;
  logic req_d_corrupt;
  logic [DATA_W-1:0] req_d_data;
  modport master (
    input req_a_valid, req_a_opcode, req_a_param, req_a_size, req_a_source, req_a_address,
          req_a_mask, req_a_data, a_ready, d_valid, d, req_d_ready,
    output req_a_ready, a_valid, a, d_ready, req_d_valid, req_d_opcode, req_d_param,
           req_d_size, req_d_source, req_d_denied, req_d_corrupt, req_d_data
  );
  modport slave (
    output req_a_valid, req_a_opcode, req_a_param, req_a_size, req_a_source, req_a_address,
           req_a_mask, req_a_data, a_ready, d_valid, d, req_d_ready,
    input req_a_ready, a_valid, a, d_ready, req_d_valid, req_d_opcode, req_d_param,
          req_d_size, req_d_source, req_d_denied, req_d_corrupt, req_d_data
  );
endinterface

// File: rtl/tl_ul_a_source_arbiter_rr_arbiter.sv
// tl_ul_a_source_arbiter_rr_arbiter: irrevocable round-robin pick among eligible requesters
// elig: eligible requesters; ready: downstream a_ready
// valid: a grant is offered; winner_oh/winner_idx: offered requester
module tl_ul_a_source_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_REQ-1:0] elig,
  input  logic ready,
  output logic valid,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0] winner_idx
);
  logic [IDX_W-1:0] rr_ptr, held, pick;
  logic lock, found;
  int j;
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (!found && elig[IDX_W'(j)]) begin
        pick = IDX_W'(j);
        found = 1'b1;
      end
    end
    // a stalled offer stays with its requester until it fires
    winner_idx = lock ? held : pick;
    valid = rst_n && (lock || found);
    winner_oh = valid ? NUM_REQ'(1) << winner_idx : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr <= '0;
      held <= '0;
      lock <= 1'b0;
    end else if (valid && ready) begin
      rr_ptr <= winner_idx == IDX_W'(NUM_REQ - 1) ? '0 : winner_idx + 1'b1;
      lock <= 1'b0;
    end else if (valid) begin
      held <= winner_idx;
      lock <= 1'b1;
    end
endmodule

// File: rtl/tl_ul_a_source_arbiter.sv
// tl_ul_a_source_arbiter: shares one TL-UL master port among NUM_REQ requesters, tags A source, routes D back
// clk, rst_n (async, active-low); bus: requester and downstream TL-UL signals (master modport)
// inflight_any: some requester has outstanding A; err_sticky: [0] bad D index, [1] D with nothing outstanding
module tl_ul_a_source_arbiter
  import tl_ul_a_source_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W = $clog2(NUM_REQ),
  parameter int MAX_INFLIGHT = 4
) (
  input  logic clk,
  input  logic rst_n,
  tl_ul_a_source_arbiter_if.master bus,
  output logic inflight_any,
  output logic [1:0] err_sticky
);
  localparam int UW = SRC_W - IDX_W;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  logic [NUM_REQ-1:0] elig, winner_oh, inc, dec;
  logic [IDX_W-1:0] widx, didx;
  logic a_valid, dok, d_fire;
  logic [CNT_W-1:0] cnt [NUM_REQ];
  always_comb begin
    elig = '0;
    inflight_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_a_valid[i] && cnt[i] < CNT_W'(MAX_INFLIGHT);
      inflight_any = inflight_any || cnt[i] != '0;
    end
  end
  tl_ul_a_source_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .clk(clk),
    .rst_n(rst_n),
    .elig(elig),
    .ready(bus.a_ready),
    .valid(a_valid),
    .winner_oh(winner_oh),
    .winner_idx(widx)
  );
  assign bus.a_valid = a_valid;
  assign bus.req_a_ready = winner_oh & {NUM_REQ{bus.a_ready}};
  assign inc = bus.req_a_ready;
  assign bus.a = '{
    opcode: bus.req_a_opcode[3*widx +: 3],
    param: bus.req_a_param[3*widx +: 3],
    size: bus.req_a_size[4*widx +: 4],
    source: {widx, bus.req_a_source[UW*widx +: UW]},
    address: bus.req_a_address[ADDR_W*widx +: ADDR_W],
    mask: bus.req_a_mask[MASK_W*widx +: MASK_W],
    data: bus.req_a_data[DATA_W*widx +: DATA_W]
  };
  // indices past NUM_REQ are acknowledged and dropped so the bus never stalls
  assign didx = bus.d.source[SRC_W-1 -: IDX_W];
  assign dok = {1'b0, didx} < (IDX_W + 1)'(NUM_REQ);
  assign bus.d_ready = dok ? bus.req_d_ready[didx] : 1'b1;
  assign d_fire = bus.d_valid && bus.d_ready;
  assign bus.req_d_valid = rst_n && bus.d_valid && dok ? NUM_REQ'(1) << didx : '0;
  assign dec = d_fire && dok ? NUM_REQ'(1) << didx : '0;
  assign bus.req_d_opcode = bus.d.opcode;
  assign bus.req_d_param = bus.d.param;
  assign bus.req_d_size = bus.d.size;
  assign bus.req_d_source = bus.d.source[UW-1:0];
  assign bus.req_d_denied = bus.d.denied;
  assign bus.req_d_corrupt = bus.d.corrupt;
  assign bus.req_d_data = bus.d.data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      err_sticky <= '0;
    end else begin
      if (d_fire && !dok) err_sticky[0] <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !inc[i]) begin
          if (cnt[i] == '0) err_sticky[1] <= 1'b1;
          else cnt[i] <= cnt[i] - 1'b1;
        end
    end
endmodule

// File: tb/tb_tl_ul_a_source_arbiter.sv
// tb_tl_ul_a_source_arbiter: table vectors, directed corner sequences and a random run against a counting model
module tb_tl_ul_a_source_arbiter;
  import tl_ul_a_source_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic inflight_any;
  logic [1:0] err_sticky;
  int errors = 0;
  int checks = 0;
  logic [3:0] src [2];
  logic [13:0] addr [2];
  logic [31:0] data [2];
  logic [2:0] op [2];
  typedef struct packed {
    logic [1:0] rv;
    logic ar;
    logic dv;
    logic [4:0] ds;
    logic [1:0] rdr;
    logic av;
    logic [1:0] rar;
    logic [4:0] asrc;
    logic [1:0] rdv;
    logic dr;
    logic [3:0] rds;
  } vec_t;
  vec_t tv [10];
  int m_cnt [2];
  int m_ptr, m_held, m_w, m_j;
  bit m_lock, m_any;
  logic [1:0] m_err, rv, rdr, e_rar;
  logic ar, dv;
  logic [4:0] ds, e_asrc;
  tl_ul_a_source_arbiter_if #(.NUM_REQ(2)) bus();
  tl_ul_a_source_arbiter #(.NUM_REQ(2), .MAX_INFLIGHT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master),
    .inflight_any(inflight_any),
    .err_sticky(err_sticky)
  );
  always #5 clk = ~clk;
  assign bus.req_a_source = {src[1], src[0]};
  assign bus.req_a_address = {addr[1], addr[0]};
  assign bus.req_a_data = {data[1], data[0]};
  assign bus.req_a_opcode = {op[1], op[0]};
  assign bus.req_a_param = '0;
  assign bus.req_a_size = {4'd2, 4'd2};
  assign bus.req_a_mask = '1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v, input logic r, input logic dval, input logic [4:0] dsrc, input logic [1:0] dr);
    bus.req_a_valid = v;
    bus.a_ready = r;
    bus.d_valid = dval;
    bus.d.source = dsrc;
    bus.req_d_ready = dr;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    drive(2'b00, 1'b0, 1'b0, 5'h00, 2'b00);
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
  endtask
  task automatic grant(input string nm, input logic [1:0] v, input logic [1:0] exp);
    drive(v, 1'b1, 1'b0, 5'h00, 2'b00);
    @(negedge clk);
    chk(nm, 64'(bus.req_a_ready), 64'(exp));
    next();
  endtask
  initial begin
    src[0] = 4'h3; src[1] = 4'hA;
    addr[0] = 14'h0100; addr[1] = 14'h0200;
    data[0] = 32'h1111_0000; data[1] = 32'h2222_0000;
    op[0] = OP_GET; op[1] = OP_PUT_FULL;
    bus.d = '0;
    bus.d.opcode = OP_ACCESS_ACK_DATA;
    tv[0] = '{2'b00, 1'b1, 1'b0, 5'h00, 2'b00, 1'b0, 2'b00, 5'h00, 2'b00, 1'b0, 4'h0};
    tv[1] = '{2'b01, 1'b1, 1'b0, 5'h00, 2'b01, 1'b1, 2'b01, 5'h03, 2'b00, 1'b1, 4'h0};
    tv[2] = '{2'b10, 1'b1, 1'b0, 5'h00, 2'b00, 1'b1, 2'b10, 5'h1A, 2'b00, 1'b0, 4'h0};
    tv[3] = '{2'b11, 1'b1, 1'b0, 5'h00, 2'b00, 1'b1, 2'b01, 5'h03, 2'b00, 1'b0, 4'h0};
    tv[4] = '{2'b11, 1'b0, 1'b0, 5'h00, 2'b00, 1'b1, 2'b00, 5'h03, 2'b00, 1'b0, 4'h0};
    tv[5] = '{2'b00, 1'b0, 1'b1, 5'h17, 2'b10, 1'b0, 2'b00, 5'h00, 2'b10, 1'b1, 4'h7};
    tv[6] = '{2'b00, 1'b0, 1'b1, 5'h17, 2'b01, 1'b0, 2'b00, 5'h00, 2'b10, 1'b0, 4'h7};
    tv[7] = '{2'b00, 1'b0, 1'b1, 5'h03, 2'b01, 1'b0, 2'b00, 5'h00, 2'b01, 1'b1, 4'h3};
    tv[8] = '{2'b10, 1'b0, 1'b0, 5'h05, 2'b10, 1'b1, 2'b00, 5'h1A, 2'b00, 1'b0, 4'h5};
    tv[9] = '{2'b01, 1'b1, 1'b1, 5'h11, 2'b11, 1'b1, 2'b01, 5'h03, 2'b10, 1'b1, 4'h1};
    drive(2'b11, 1'b1, 1'b1, 5'h10, 2'b11);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset a_valid", 64'(bus.a_valid), 64'(0));
    chk("reset req_a_ready", 64'(bus.req_a_ready), 64'(0));
    chk("reset req_d_valid", 64'(bus.req_d_valid), 64'(0));
    chk("reset d_ready routing", 64'(bus.d_ready), 64'(1));
    chk("reset inflight/err", 64'({inflight_any, err_sticky}), 64'(0));
    drive(2'b00, 1'b0, 1'b0, 5'h00, 2'b00);
    next();
    rst_n = 1'b1;
    // each vector is cleared before the edge, so state stays at reset values
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].rv, tv[i].ar, tv[i].dv, tv[i].ds, tv[i].rdr);
      @(negedge clk);
      chk($sformatf("tbl%0d a_valid", i), 64'(bus.a_valid), 64'(tv[i].av));
      chk($sformatf("tbl%0d req_a_ready", i), 64'(bus.req_a_ready), 64'(tv[i].rar));
      if (tv[i].av) chk($sformatf("tbl%0d a_source", i), 64'(bus.a.source), 64'(tv[i].asrc));
      chk($sformatf("tbl%0d req_d_valid", i), 64'(bus.req_d_valid), 64'(tv[i].rdv));
      chk($sformatf("tbl%0d d_ready", i), 64'(bus.d_ready), 64'(tv[i].dr));
      chk($sformatf("tbl%0d req_d_source", i), 64'(bus.req_d_source), 64'(tv[i].rds));
      drive(2'b00, 1'b0, 1'b0, 5'h00, 2'b00);
      next();
    end
    do_reset();
    for (int i = 0; i < 4; i++) grant($sformatf("alt grant %0d", i), 2'b11, i % 2 == 0 ? 2'b01 : 2'b10);
    drive(2'b01, 1'b0, 1'b0, 5'h00, 2'b00);
    next();
    drive(2'b11, 1'b0, 1'b0, 5'h00, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset a_valid", 64'(bus.a_valid), 64'(0));
    chk("midreset inflight_any", 64'(inflight_any), 64'(0));
    next();
    rst_n = 1'b1;
    grant("post reset grant", 2'b11, 2'b01);
    drive(2'b00, 1'b0, 1'b1, 5'h12, 2'b10);
    @(negedge clk);
    chk("stale D d_ready", 64'(bus.d_ready), 64'(1));
    next();
    drive(2'b00, 1'b0, 1'b0, 5'h00, 2'b00);
    @(negedge clk);
    chk("stale D err/inflight", 64'({inflight_any, err_sticky}), 64'(3'b110));
    next();
    do_reset();
    grant("lock pre grant", 2'b01, 2'b01);
    addr[0] = 14'h1234;
    for (int c = 0; c < 3; c++) begin
      drive(c == 0 ? 2'b01 : 2'b11, 1'b0, 1'b0, 5'h00, 2'b00);
      @(negedge clk);
      chk("lock a_valid", 64'(bus.a_valid), 64'(1));
      chk("lock req_a_ready", 64'(bus.req_a_ready), 64'(0));
      chk("lock held payload", 64'({bus.a.source, bus.a.address}), 64'({5'h03, 14'h1234}));
      next();
    end
    grant("lock release", 2'b11, 2'b01);
    grant("after lock req1", 2'b11, 2'b10);
    do_reset();
    for (int i = 0; i < 4; i++) grant($sformatf("fill %0d", i), 2'b01, 2'b01);
    drive(2'b01, 1'b1, 1'b1, 5'h03, 2'b01);
    @(negedge clk);
    chk("full req_a_ready", 64'(bus.req_a_ready), 64'(0));
    chk("full a_valid", 64'(bus.a_valid), 64'(0));
    chk("full d_ready", 64'(bus.d_ready), 64'(1));
    next();
    drive(2'b01, 1'b1, 1'b1, 5'h01, 2'b01);
    @(negedge clk);
    chk("refill grant", 64'(bus.req_a_ready), 64'(2'b01));
    next();
    grant("a+d same cycle keeps count", 2'b01, 2'b01);
    grant("full again", 2'b01, 2'b00);
    @(negedge clk);
    chk("full err_sticky", 64'(err_sticky), 64'(0));
    next();
    do_reset();
    grant("route pre grant", 2'b10, 2'b10);
    bus.d.data = 32'hCAFE_F00D;
    drive(2'b00, 1'b0, 1'b1, 5'h17, 2'b00);
    @(negedge clk);
    chk("route req_d_valid", 64'(bus.req_d_valid), 64'(2'b10));
    chk("route req_d_source", 64'(bus.req_d_source), 64'(4'h7));
    chk("route d_ready blocked", 64'(bus.d_ready), 64'(0));
    chk("route req_d_data", 64'(bus.req_d_data), 64'(32'hCAFE_F00D));
    next();
    drive(2'b00, 1'b0, 1'b1, 5'h17, 2'b10);
    @(negedge clk);
    chk("route d_ready open", 64'(bus.d_ready), 64'(1));
    next();
    drive(2'b00, 1'b0, 1'b0, 5'h00, 2'b00);
    @(negedge clk);
    chk("route drained", 64'({inflight_any, err_sticky}), 64'(0));
    next();
    do_reset();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_ptr = 0; m_held = 0; m_lock = 0; m_err = 2'b00;
    for (int c = 0; c < 600; c++) begin
      rv = 2'($urandom);
      ar = $urandom_range(0, 9) < 7;
      dv = 1'($urandom);
      ds = 5'($urandom);
      rdr = 2'($urandom);
      if (m_lock) rv[m_held] = 1'b1;
      for (int i = 0; i < 2; i++)
        if (!(m_lock && m_held == i)) begin
          src[i] = 4'($urandom);
          addr[i] = 14'($urandom);
          data[i] = $urandom;
          op[i] = $urandom_range(0, 1) == 0 ? OP_GET : OP_PUT_FULL;
        end
      drive(rv, ar, dv, ds, rdr);
      m_any = m_lock;
      m_w = m_held;
      for (int k = 0; k < 2; k++) begin
        m_j = (m_ptr + k) % 2;
        if (!m_any && rv[m_j] && m_cnt[m_j] < 4) begin
          m_any = 1;
          m_w = m_j;
        end
      end
      e_rar = (m_any && ar) ? 2'(1 << m_w) : 2'b00;
      e_asrc = {m_w[0], src[m_w]};
      @(negedge clk);
      chk("rnd a_valid", 64'(bus.a_valid), 64'(m_any));
      chk("rnd req_a_ready", 64'(bus.req_a_ready), 64'(e_rar));
      if (m_any) chk("rnd a payload", 64'({bus.a.source, bus.a.address, bus.a.data, bus.a.opcode}),
                     64'({e_asrc, addr[m_w], data[m_w], op[m_w]}));
      chk("rnd req_d_valid", 64'(bus.req_d_valid), 64'(dv ? 2'(1 << ds[4]) : 2'b00));
      chk("rnd d_ready", 64'(bus.d_ready), 64'(rdr[ds[4]]));
      chk("rnd req_d_source", 64'(bus.req_d_source), 64'(ds[3:0]));
      chk("rnd inflight/err", 64'({inflight_any, err_sticky}), 64'({(m_cnt[0] + m_cnt[1]) != 0, m_err}));
      if (m_any && ar) begin
        m_cnt[m_w]++;
        m_ptr = (m_w + 1) % 2;
        m_lock = 0;
      end else if (m_any) begin
        m_lock = 1;
        m_held = m_w;
      end
      if (dv && rdr[ds[4]]) begin
        if (m_cnt[ds[4]] == 0) m_err[1] = 1'b1;
        else m_cnt[ds[4]]--;
      end
      next();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
